knn_dist_ctrl: RTL and testbench

//  Sequencer for the distance unit. On start, it streams training points 0..num from the point memory into the distance

---
 rtl/knn_pkg.sv | 25 ++
 rtl/knn_fetch_fifo.sv | 41 ++++
 rtl/knn_dist_ctrl.sv | 161 ++++++++++++++++
 tb/tb_knn_dist_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared types and widths for the k-NN distance sequencer.
package knn_pkg;

  localparam int KNN_WIDTH = 4;
  localparam int KNN_TAG   = 2;
  localparam int PT_W      = KNN_TAG + KNN_WIDTH;
  localparam int DIST_W    = KNN_TAG + 2 * KNN_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } knn_ctrl_state_e;

  typedef enum logic [1:0] {
    SEL_EUC = 2'b00,
    SEL_SQ  = 2'b01,
    SEL_MAN = 2'b10
  } dist_sel_e;

  localparam logic [1:0] SEL_ILLEGAL = 2'b11;

endpackage

// File: rtl/knn_fetch_fifo.sv
// Two-entry FIFO buffering point-memory read data ahead of the distance unit.
module knn_fetch_fifo #(
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/knn_dist_ctrl.sv
// Sequencer feeding training points to the distance unit and forwarding results to the sorter.
// Optional KNN_CTRL_PERF_EN adds busy-cycle and issue-stall counters.
module knn_dist_ctrl
  import knn_pkg::*;
#(
  parameter int WIDTH    = KNN_WIDTH,
  parameter int TAG      = KNN_TAG,
  parameter int MEM_SIZE = 1024,
  parameter int MAX_OUT  = 4,
  localparam int IW      = $clog2(MEM_SIZE),
  localparam int PW      = TAG + WIDTH,
  localparam int DW      = TAG + 2 * WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [IW-1:0] num_i,
  input  logic [1:0]    sel_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          mem_re_o,
  output logic [IW-1:0] mem_addr_o,
  input  logic [PW-1:0] mem_x_i,
  input  logic [PW-1:0] mem_y_i,
  output logic          dist_valid_o,
  input  logic          dist_ready_i,
  output logic [PW-1:0] dist_x2_o,
  output logic [PW-1:0] dist_y2_o,
  output logic [1:0]    dist_sel_o,
  input  logic          res_valid_i,
  input  logic [DW-1:0] res_dist_i,
  output logic          res_yumi_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_dist_o,
  output logic [IW-1:0] out_idx_o,
  output logic          out_last_o,
`ifdef KNN_CTRL_PERF_EN
  output logic [31:0]   perf_cycles_o,
  output logic [31:0]   perf_stall_o,
`endif
  output logic [2:0]    state_o
);

  // Handshakes: a point moves to the distance unit when dist_valid_o & dist_ready_i
  // (offer held stable until then); a result is consumed when res_yumi_o is high.
  knn_ctrl_state_e state;
  logic [IW-1:0]   num_q;
  logic [1:0]      sel_q;
  logic [IW-1:0]   res_idx;
  logic [IW:0]     fetch_ptr;
  logic            rd_pend;
  logic [3:0]      inflight;
  logic [1:0]      fifo_cnt;
  logic            fire;
  logic            fetch_left;
  logic            fifo_room;
  logic            credit_ok;
  logic            last_yumi;

  knn_fetch_fifo #(.W(2 * PW)) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (rd_pend),
    .push_data ({mem_x_i, mem_y_i}),
    .pop       (fire),
    .head      ({dist_x2_o, dist_y2_o}),
    .cnt       (fifo_cnt)
  );

  assign fire         = dist_valid_o & dist_ready_i;
  assign dist_valid_o = (fifo_cnt != 2'd0);
  assign busy_o       = (state == RUN) | (state == DRAIN) | (state == ERR);
  assign out_valid_o  = res_valid_i & busy_o;
  assign res_yumi_o   = res_valid_i & out_ready_i & busy_o;
  assign out_dist_o   = res_dist_i;
  assign out_idx_o    = res_idx;
  assign out_last_o   = out_valid_o & (res_idx == num_q);
  assign last_yumi    = res_yumi_o & (res_idx == num_q);
  assign dist_sel_o   = sel_q;
  assign state_o      = state;

  // A pop in the same cycle frees a FIFO slot, so the fetch path sustains one point per cycle.
  assign fetch_left = (fetch_ptr <= {1'b0, num_q});
  assign fifo_room  = ({1'b0, fifo_cnt} + {2'b0, rd_pend}) < (3'd2 + {2'b0, fire});
  assign credit_ok  = ({1'b0, inflight} + {3'b0, fifo_cnt} + {4'b0, rd_pend}) < 5'(MAX_OUT);
  assign mem_re_o   = (state == RUN) & fetch_left & fifo_room & credit_ok;
  assign mem_addr_o = fetch_ptr[IW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      num_q     <= '0;
      sel_q     <= 2'b00;
      err_o     <= 1'b0;
      done_o    <= 1'b0;
      fetch_ptr <= '0;
      rd_pend   <= 1'b0;
      inflight  <= 4'd0;
      res_idx   <= '0;
    end else begin
      done_o  <= 1'b0;
      rd_pend <= mem_re_o;
      if (mem_re_o) fetch_ptr <= fetch_ptr + 1'b1;
      if (fire && !res_yumi_o) inflight <= inflight + 4'd1;
      else if (!fire && res_yumi_o) inflight <= inflight - 4'd1;
      if (res_yumi_o) res_idx <= res_idx + 1'b1;
      case (state)
        IDLE: begin
          if (start_i) begin
            num_q     <= num_i;
            sel_q     <= sel_i;
            fetch_ptr <= '0;
            res_idx   <= '0;
            inflight  <= 4'd0;
            err_o     <= (sel_i == SEL_ILLEGAL);
            state     <= (sel_i == SEL_ILLEGAL) ? ERR : RUN;
          end
        end
        RUN: begin
          // A zero-latency distance unit can return the last result before RUN is left.
          if (last_yumi) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else if (!fetch_left && fifo_cnt == 2'd0 && !rd_pend) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_yumi) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        ERR: begin
          state  <= DONE;
          done_o <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KNN_CTRL_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_o <= '0;
      perf_stall_o  <= '0;
    end else if (state == IDLE && start_i) begin
      perf_cycles_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (busy_o && perf_cycles_o != '1) perf_cycles_o <= perf_cycles_o + 32'd1;
      if (dist_valid_o && !dist_ready_i && perf_stall_o != '1) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_knn_dist_ctrl.sv
// Bench for knn_dist_ctrl: memory and distance-unit responders, result scoreboard, table and corner runs.
module tb_knn_dist_ctrl;
  import knn_pkg::*;

  localparam int IW = 10, PW = 6, DW = 10, MEM_SIZE = 1024, MAX_OUT = 4, RES_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [IW-1:0] num_i = '0;
  logic [1:0]    sel_i = '0;
  logic          busy_o, done_o, err_o, mem_re_o;
  logic [IW-1:0] mem_addr_o;
  logic [PW-1:0] mem_x_i = '0, mem_y_i = '0;
  logic          dist_valid_o;
  logic          dist_ready_i = 1'b0;
  logic [PW-1:0] dist_x2_o, dist_y2_o;
  logic [1:0]    dist_sel_o;
  logic          res_valid_i = 1'b0;
  logic [DW-1:0] res_dist_i = '0;
  logic          res_yumi_o, out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_dist_o;
  logic [IW-1:0] out_idx_o;
  logic          out_last_o;
  logic [2:0]    state_o;
`ifdef KNN_CTRL_PERF_EN
  logic [31:0]   perf_cycles_o, perf_stall_o;
`endif

  knn_dist_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .num_i(num_i), .sel_i(sel_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o),
    .mem_x_i(mem_x_i), .mem_y_i(mem_y_i), .dist_valid_o(dist_valid_o), .dist_ready_i(dist_ready_i),
    .dist_x2_o(dist_x2_o), .dist_y2_o(dist_y2_o), .dist_sel_o(dist_sel_o), .res_valid_i(res_valid_i),
    .res_dist_i(res_dist_i), .res_yumi_o(res_yumi_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_dist_o(out_dist_o), .out_idx_o(out_idx_o), .out_last_o(out_last_o),
`ifdef KNN_CTRL_PERF_EN
    .perf_cycles_o(perf_cycles_o), .perf_stall_o(perf_stall_o),
`endif
    .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dist_f(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [7:0] p;
    p = x[3:0] * y[3:0];
    return {x[PW-1:PW-2], p};
  endfunction

  // ---------------- responders: point memory and distance unit ----------------
  logic [PW-1:0] pm_x [MEM_SIZE];
  logic [PW-1:0] pm_y [MEM_SIZE];

  always @(posedge clk) begin
    if (mem_re_o) begin
      mem_x_i <= pm_x[mem_addr_o];
      mem_y_i <= pm_y[mem_addr_o];
    end
  end

  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } res_t;
  res_t rq[$];
  int   cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq.delete();
      res_valid_i <= 1'b0;
      res_dist_i  <= '0;
    end else begin
      cyc++;
      if (res_yumi_o && rq.size() > 0) void'(rq.pop_front());
      if (dist_valid_o && dist_ready_i) rq.push_back('{dist_f(dist_x2_o, dist_y2_o), cyc});
      if (rq.size() > 0 && (cyc - rq[0].t) >= RES_LAT) begin
        res_valid_i <= 1'b1;
        res_dist_i  <= rq[0].d;
      end else begin
        res_valid_i <= 1'b0;
        res_dist_i  <= '0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [20:0]   exp_q[$];
  int            fire_cnt, re_cnt, yumi_cnt, done_cnt, busy_cnt, stall_cnt;
  int            first_re_cyc, last_re_cyc, done_cyc, start_cyc, cur_num;
  logic          held = 1'b0;
  logic [11:0]   held_pt;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (mem_re_o) begin
        check("mem_addr", 32'(mem_addr_o), 32'(re_cnt));
        if (re_cnt == 0) first_re_cyc = cyc;
        last_re_cyc = cyc;
        re_cnt++;
      end
      if (held) begin
        check("hold_valid", 32'(dist_valid_o), 32'd1);
        check("hold_point", 32'({dist_x2_o, dist_y2_o}), 32'(held_pt));
      end
      held    = dist_valid_o && !dist_ready_i;
      held_pt = {dist_x2_o, dist_y2_o};
      if (dist_valid_o && dist_ready_i) fire_cnt++;
      check("yumi_rule", 32'(res_yumi_o), 32'(out_valid_o && out_ready_i));
      if (out_valid_o && out_ready_i) begin
        check("result_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("out_result", 32'({out_last_o, out_idx_o, out_dist_o}), 32'(exp_q.pop_front()));
        yumi_cnt++;
      end
      check("credit_limit", 32'((fire_cnt - yumi_cnt) <= MAX_OUT), 32'd1);
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy_o) busy_cnt++;
      if (dist_valid_o && !dist_ready_i) stall_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input int num, input logic [1:0] sel);
    for (int i = 0; i < MEM_SIZE; i++) begin
      pm_x[i] = PW'($urandom);
      pm_y[i] = PW'($urandom);
    end
    exp_q.delete();
    if (sel != 2'b11)
      for (int i = 0; i <= num; i++) exp_q.push_back({i == num, IW'(i), dist_f(pm_x[i], pm_y[i])});
    fire_cnt = 0; re_cnt = 0; yumi_cnt = 0; done_cnt = 0; busy_cnt = 0; stall_cnt = 0;
    first_re_cyc = -1; last_re_cyc = -1; done_cyc = -1; cur_num = num;
    @(posedge clk); #1;
    start_i = 1'b1; num_i = IW'(num); sel_i = sel; start_cyc = cyc;
    @(posedge clk); #1;
    start_i = 1'b0; num_i = IW'($urandom); sel_i = 2'($urandom);
    check("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  task automatic finish_run(input int dpct, input int opct, input logic exp_err, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      dist_ready_i = ($urandom_range(99) < dpct);
      out_ready_i  = ($urandom_range(99) < opct);
      @(posedge clk); #1;
      k++;
    end
    check("done_in_time", 32'(done_cnt != 0), 32'd1);
    @(posedge clk); #1;
    check("done_count", 32'(done_cnt), 32'd1);
    check("err_flag", 32'(err_o), 32'(exp_err));
    check("busy_idle", 32'(busy_o), 32'd0);
    check("results_left", 32'(exp_q.size()), 32'd0);
    check("fire_total", 32'(fire_cnt), exp_err ? 32'd0 : 32'(cur_num + 1));
    check("read_total", 32'(re_cnt), exp_err ? 32'd0 : 32'(cur_num + 1));
    if (exp_err) check("err_done_latency", 32'(done_cyc - start_cyc), 32'd2);
    else check("first_re_latency", 32'(first_re_cyc - start_cyc), 32'd1);
`ifdef KNN_CTRL_PERF_EN
    check("perf_cycles", perf_cycles_o, 32'(busy_cnt));
    check("perf_stall", perf_stall_o, 32'(stall_cnt));
`endif
  endtask

  typedef struct {
    int         num;
    logic [1:0] sel;
    int         dpct;
    int         opct;
    logic       err;
  } vec_t;

  // ---------------- test sequence ----------------
  initial begin
    vec_t vt[7];
    vt = '{'{0, 2'b10, 100, 100, 1'b0}, '{11, 2'b11, 100, 100, 1'b1}, '{7, 2'b00, 60, 70, 1'b0},
           '{15, 2'b01, 30, 40, 1'b0}, '{12, 2'b10, 80, 20, 1'b0}, '{2, 2'b01, 50, 50, 1'b0},
           '{1023, 2'b01, 100, 100, 1'b0}};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_o), 0);       check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);         check("rst_mem_re", 32'(mem_re_o), 0);
    check("rst_dist_valid", 32'(dist_valid_o), 0); check("rst_out_valid", 32'(out_valid_o), 0);
    check("rst_out_last", 32'(out_last_o), 0);     check("rst_state", 32'(state_o), 32'(IDLE));
    rst_n = 1'b1;

    // back-to-back fetch with everything ready
    start_run(3, 2'b01);
    finish_run(100, 100, 1'b0, 100);
    check("addr_back_to_back", 32'(last_re_cyc - first_re_cyc), 32'd3);

    for (int i = 0; i < 7; i++) begin
      start_run(vt[i].num, vt[i].sel);
      finish_run(vt[i].dpct, vt[i].opct, vt[i].err, 4000);
    end

    // credit limit with sorter stalled
    dist_ready_i = 1'b1; out_ready_i = 1'b0;
    start_run(9, 2'b01);
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("credit_fires", 32'(fire_cnt), 32'd4);
    check("credit_reads", 32'(re_cnt), 32'd4);
    check("credit_no_valid", 32'(dist_valid_o), 32'd0);
    check("credit_no_re", 32'(mem_re_o), 32'd0);
    finish_run(100, 100, 1'b0, 200);

    // reset mid-run, then a clean run
    dist_ready_i = 1'b1; out_ready_i = 1'b0;
    start_run(9, 2'b01);
    for (int k = 0; k < 50 && fire_cnt < 2; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy_o), 0);        check("abort_mem_re", 32'(mem_re_o), 0);
    check("abort_dist_valid", 32'(dist_valid_o), 0); check("abort_out_valid", 32'(out_valid_o), 0);
    check("abort_yumi", 32'(res_yumi_o), 0);    check("abort_idx", 32'(out_idx_o), 0);
    check("abort_addr", 32'(mem_addr_o), 0);    check("abort_sel", 32'(dist_sel_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("abort_no_done", 32'(done_cnt), 32'd0);
    start_run(3, 2'b00);
    finish_run(100, 100, 1'b0, 100);

    // start during RUN is ignored
    dist_ready_i = 1'b1; out_ready_i = 1'b0;
    start_run(5, 2'b10);
    @(posedge clk); #1;
    start_i = 1'b1; num_i = 10'd2; sel_i = 2'b00;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("ignored_start_sel", 32'(dist_sel_o), 32'd2);
    finish_run(100, 100, 1'b0, 200);

`ifdef KNN_CTRL_PERF_EN
    dist_ready_i = 1'b0; out_ready_i = 1'b1;
    start_run(0, 2'b01);
    for (int k = 0; k < 20 && !dist_valid_o; k++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1 dist_ready_i = 1'b1;
    finish_run(100, 100, 1'b0, 100);
    check("perf_stall_three", perf_stall_o, 32'd3);
`endif

    // randomized runs
    repeat (6) begin
      start_run($urandom_range(40), 2'($urandom_range(2)));
      finish_run($urandom_range(100, 20), $urandom_range(100, 20), 1'b0, 4000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
